forwarding_unit: RTL and testbench
==================================

Name: forwarding_unit

Overview:
Data-hazard forwarding selector for the 5-stage MIPS32 pipeline.
- Compares source register numbers in EX (rs, rt) and ID (rsID, rtID) against the destinations of younger-stage writers.
- Produces 2-bit bypass-mux selects combinationally.
- A small clocked block keeps saturating forwarding-event counters for performance debug.

Parameters:
CNT_W, 16, width of each forwarding-event counter (≥1)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
rs  input  5  EX-stage source register A
rt  input  5  EX-stage source register B
rsID  input  5  ID-stage source register A
rtID  input  5  ID-stage source register B
destRegEX  input  5  destination register of the instruction in EX
destRegMEM  input  5  destination register of the instruction in MEM
destRegWB  input  5  destination register of the instruction in WB
regWriteEX  input  1  EX instruction writes the register file
regWriteMEM  input  1  MEM instruction writes the register file
regWriteWB  input  1  WB instruction writes the register file
cntClear  input  1  synchronous clear of all counters
forwardRS  output  2  EX bypass select for rs
forwardRT  output  2  EX bypass select for rt
forwardRSID  output  2  ID bypass select for rsID
forwardRTID  output  2  ID bypass select for rtID
cntFwdMEM  output  CNT_W  cycles with any EX-stage forward sourced from MEM
cntFwdWB  output  CNT_W  cycles with any EX-stage forward sourced from WB
cntFwdEX  output  CNT_W  cycles with any ID-stage forward sourced from EX
cntFwdIDMEM  output  CNT_W  cycles with any ID-stage forward sourced from MEM

Behaviour:
- Select outputs are purely combinational, with zero latency. They are independent of Clock and Reset.
- EX-stage select, applied identically to rs→forwardRS and rt→forwardRT:
  - src==destRegMEM && regWriteMEM → 2'b01
  - else src==destRegWB && regWriteWB → 2'b10
  - else → 2'b00
- ID-stage select, applied identically to rsID→forwardRSID and rtID→forwardRTID:
  - src==destRegEX && regWriteEX → 2'b01
  - else src==destRegMEM && regWriteMEM → 2'b10
  - else → 2'b00
- Priority: the nearer stage always wins when both stages match.
- Select value 2'b11 is never produced.
- A destination match with its regWrite=0 never forwards.
- Register 0 is compared like any other register (see Optional Feature).
- Counters:
  - Reset low → all counters 0 immediately (asynchronous).
  - On a rising edge with Reset high:
    - cntClear=1 → all counters 0; cntClear has priority over increments.
    - Otherwise each counter increments by 1 when its condition holds that cycle.
  - Counter conditions:
    - cntFwdMEM: forwardRS==01 || forwardRT==01
    - cntFwdWB: forwardRS==10 || forwardRT==10
    - cntFwdEX: forwardRSID==01 || forwardRTID==01
    - cntFwdIDMEM: forwardRSID==10 || forwardRTID==10
  - Counters saturate at 2^CNT_W−1; no wrap-around.
  - A cycle with two matching operands counts once.

Optional Feature:
ZERO_REG_GUARD_EN
- Defined: any comparison whose source register is 5'd0 is forced to no-match. The corresponding select is 2'b00 and does not increment any counter. This implements MIPS $zero semantics.
- Not defined: register 0 is treated like any other register, per Behaviour.

Decomposition:
- Shared package: the select encodings FWD_NONE=2'b00, FWD_NEAR=2'b01, FWD_FAR=2'b10, and the register-index width constant REG_W=5.
- One sub-module, fwd_select: a 2-level priority comparator taking one source, near/far destination and near/far write enable, and producing a 2-bit select.
- fwd_select is instantiated four times. Counters live in the top module.

Test Plan:
- All regs=31, all regWrite=1 → forwardRS/RT=01, forwardRSID/RTID=01.
- All regs=31, regWriteEX=0, MEM=1, WB=1 → RS/RT=01, RSID/RTID=10.
- All regs=31, only regWriteWB=1 → RS/RT=10, RSID/RTID=00.
- rs=rt=31, rsID=27, rtID=23, destEX=23, destMEM=11, destWB=13, regWriteEX=1, MEM=1, WB=0 → RS/RT=00, RSID=00, RTID=01. Repeat with all regWrite=0 → all 00.
- rt=15, destWB=15, regWriteWB=1, others non-matching → forwardRT=10, forwardRS=00. Clock 3 cycles → cntFwdWB=3. Pulse cntClear → 0. Drop Reset mid-count → counters 0 asynchronously.
- 500 random vectors with random regWrite bits, checked against a reference model. Then rs=0, destMEM=0, regWriteMEM=1 → 01 without ZERO_REG_GUARD_EN, 00 with it. Set CNT_W=2 and hold a match for 5 cycles → counter saturates at 3.

Source files
------------

// File: rtl/forwarding_unit_pkg.sv
// rtl/forwarding_unit_pkg.sv - shared constants for the forwarding unit
// Purpose: bypass-select encodings and register-index width used by
//          forwarding_unit and fwd_select.
package forwarding_unit_pkg;

    localparam int REG_W = 5;

    // Bypass-mux select encodings. "Near" is the younger writer (closer to
    // the consumer), "far" the older one. 2'b11 is never produced.
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_NEAR = 2'b01;
    localparam logic [1:0] FWD_FAR  = 2'b10;

endpackage

// File: rtl/forwarding_unit_fwd_select.sv
// rtl/forwarding_unit_fwd_select.sv - two-level priority forwarding comparator
// Purpose: picks the bypass source for one operand from a near and a far
//          writer; the near writer wins when both match.
// Ports:
//   src       in  REG_W  source register number of the consumer
//   nearDest  in  REG_W  destination of the nearer writer
//   farDest   in  REG_W  destination of the farther writer
//   nearWrite in  1      nearer writer updates the register file
//   farWrite  in  1      farther writer updates the register file
//   sel       out 2      FWD_NONE / FWD_NEAR / FWD_FAR
// Option: ZERO_REG_GUARD_EN - source register 0 never matches ($zero).
module fwd_select
    import forwarding_unit_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] nearDest,
    input  logic [REG_W-1:0] farDest,
    input  logic             nearWrite,
    input  logic             farWrite,
    output logic [1:0]       sel
);

    logic srcLive;

`ifdef ZERO_REG_GUARD_EN
    // $zero is hard-wired, so a write to it must never be bypassed.
    assign srcLive = |src;
`else
    assign srcLive = 1'b1;
`endif

    always_comb begin
        sel = FWD_NONE;
        if (srcLive && nearWrite && (src == nearDest)) begin
            sel = FWD_NEAR;
        end else if (srcLive && farWrite && (src == farDest)) begin
            sel = FWD_FAR;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - MIPS32 5-stage data-hazard forwarding selector
// Purpose: combinational bypass selects for EX (rs/rt) and ID (rsID/rtID)
//          operands, plus saturating forwarding-event counters.
// Ports:
//   Clock, Reset (async, active-low)   counters only; selects ignore them
//   rs, rt, rsID, rtID                 consumer source registers
//   destRegEX/MEM/WB, regWriteEX/MEM/WB writer destinations and enables
//   cntClear                           synchronous clear of all counters
//   forwardRS/RT                       EX selects: 01=MEM, 10=WB
//   forwardRSID/RTID                   ID selects: 01=EX,  10=MEM
//   cntFwdMEM/WB/EX/IDMEM              event counters, CNT_W bits
// Option: ZERO_REG_GUARD_EN - register 0 never forwards.
module forwarding_unit
    import forwarding_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rsID,
    input  logic [REG_W-1:0] rtID,
    input  logic [REG_W-1:0] destRegEX,
    input  logic [REG_W-1:0] destRegMEM,
    input  logic [REG_W-1:0] destRegWB,
    input  logic             regWriteEX,
    input  logic             regWriteMEM,
    input  logic             regWriteWB,
    input  logic             cntClear,
    output logic [1:0]       forwardRS,
    output logic [1:0]       forwardRT,
    output logic [1:0]       forwardRSID,
    output logic [1:0]       forwardRTID,
    output logic [CNT_W-1:0] cntFwdMEM,
    output logic [CNT_W-1:0] cntFwdWB,
    output logic [CNT_W-1:0] cntFwdEX,
    output logic [CNT_W-1:0] cntFwdIDMEM
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // EX-stage consumers: MEM is near, WB is far.
    fwd_select uSelRS (
        .src(rs), .nearDest(destRegMEM), .farDest(destRegWB),
        .nearWrite(regWriteMEM), .farWrite(regWriteWB), .sel(forwardRS)
    );
    fwd_select uSelRT (
        .src(rt), .nearDest(destRegMEM), .farDest(destRegWB),
        .nearWrite(regWriteMEM), .farWrite(regWriteWB), .sel(forwardRT)
    );

    // ID-stage consumers: EX is near, MEM is far.
    fwd_select uSelRSID (
        .src(rsID), .nearDest(destRegEX), .farDest(destRegMEM),
        .nearWrite(regWriteEX), .farWrite(regWriteMEM), .sel(forwardRSID)
    );
    fwd_select uSelRTID (
        .src(rtID), .nearDest(destRegEX), .farDest(destRegMEM),
        .nearWrite(regWriteEX), .farWrite(regWriteMEM), .sel(forwardRTID)
    );

    // One event per cycle even when both operands forward from the same stage.
    logic hitMEM, hitWB, hitEX, hitIDMEM;

    assign hitMEM   = (forwardRS   == FWD_NEAR) || (forwardRT   == FWD_NEAR);
    assign hitWB    = (forwardRS   == FWD_FAR)  || (forwardRT   == FWD_FAR);
    assign hitEX    = (forwardRSID == FWD_NEAR) || (forwardRTID == FWD_NEAR);
    assign hitIDMEM = (forwardRSID == FWD_FAR)  || (forwardRTID == FWD_FAR);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cntFwdMEM   <= '0;
            cntFwdWB    <= '0;
            cntFwdEX    <= '0;
            cntFwdIDMEM <= '0;
        end else if (cntClear) begin
            cntFwdMEM   <= '0;
            cntFwdWB    <= '0;
            cntFwdEX    <= '0;
            cntFwdIDMEM <= '0;
        end else begin
            // Saturate at all-ones so a long run never wraps back to small values.
            if (hitMEM && (cntFwdMEM != CNT_MAX)) begin
                cntFwdMEM <= cntFwdMEM + CNT_ONE;
            end
            if (hitWB && (cntFwdWB != CNT_MAX)) begin
                cntFwdWB <= cntFwdWB + CNT_ONE;
            end
            if (hitEX && (cntFwdEX != CNT_MAX)) begin
                cntFwdEX <= cntFwdEX + CNT_ONE;
            end
            if (hitIDMEM && (cntFwdIDMEM != CNT_MAX)) begin
                cntFwdIDMEM <= cntFwdIDMEM + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
// tb/tb_forwarding_unit.sv - self-checking bench for forwarding_unit
module tb_forwarding_unit;

    logic       Clock;
    logic       Reset;
    logic [4:0] rs, rt, rsID, rtID;
    logic [4:0] destRegEX, destRegMEM, destRegWB;
    logic       regWriteEX, regWriteMEM, regWriteWB;
    logic       cntClear;

    logic [1:0]  forwardRS, forwardRT, forwardRSID, forwardRTID;
    logic [15:0] cntFwdMEM, cntFwdWB, cntFwdEX, cntFwdIDMEM;
    logic [1:0]  forwardRS2, forwardRT2, forwardRSID2, forwardRTID2;
    logic [1:0]  cntFwdMEM2, cntFwdWB2, cntFwdEX2, cntFwdIDMEM2;

    int errors = 0;
    int checks = 0;

    forwarding_unit #(.CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .rs(rs), .rt(rt), .rsID(rsID), .rtID(rtID),
        .destRegEX(destRegEX), .destRegMEM(destRegMEM), .destRegWB(destRegWB),
        .regWriteEX(regWriteEX), .regWriteMEM(regWriteMEM), .regWriteWB(regWriteWB),
        .cntClear(cntClear),
        .forwardRS(forwardRS), .forwardRT(forwardRT),
        .forwardRSID(forwardRSID), .forwardRTID(forwardRTID),
        .cntFwdMEM(cntFwdMEM), .cntFwdWB(cntFwdWB),
        .cntFwdEX(cntFwdEX), .cntFwdIDMEM(cntFwdIDMEM)
    );

    forwarding_unit #(.CNT_W(2)) dut2 (
        .Clock(Clock), .Reset(Reset),
        .rs(rs), .rt(rt), .rsID(rsID), .rtID(rtID),
        .destRegEX(destRegEX), .destRegMEM(destRegMEM), .destRegWB(destRegWB),
        .regWriteEX(regWriteEX), .regWriteMEM(regWriteMEM), .regWriteWB(regWriteWB),
        .cntClear(cntClear),
        .forwardRS(forwardRS2), .forwardRT(forwardRT2),
        .forwardRSID(forwardRSID2), .forwardRTID(forwardRTID2),
        .cntFwdMEM(cntFwdMEM2), .cntFwdWB(cntFwdWB2),
        .cntFwdEX(cntFwdEX2), .cntFwdIDMEM(cntFwdIDMEM2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Index order everywhere: 0=RS/MEM, 1=RT/WB, 2=RSID/EX, 3=RTID/IDMEM
    logic [1:0]  gotSel [4];
    logic [15:0] got16  [4];
    logic [1:0]  got2   [4];
    assign gotSel[0] = forwardRS;   assign gotSel[1] = forwardRT;
    assign gotSel[2] = forwardRSID; assign gotSel[3] = forwardRTID;
    assign got16[0] = cntFwdMEM;    assign got16[1] = cntFwdWB;
    assign got16[2] = cntFwdEX;     assign got16[3] = cntFwdIDMEM;
    assign got2[0]  = cntFwdMEM2;   assign got2[1]  = cntFwdWB2;
    assign got2[2]  = cntFwdEX2;    assign got2[3]  = cntFwdIDMEM2;

    string selName [4] = '{"forwardRS", "forwardRT", "forwardRSID", "forwardRTID"};
    string cntName [4] = '{"cntFwdMEM", "cntFwdWB", "cntFwdEX", "cntFwdIDMEM"};

    typedef struct {
        logic [4:0] vrs, vrt, vrsID, vrtID, dEX, dMEM, dWB;
        logic       wEX, wMEM, wWB;
        logic [1:0] e [4];
    } vec_t;

    // Reference model: a consumer takes the youngest stage that writes its register.
    logic [1:0] expSel [4];
    int         m16 [4];
    int         m2  [4];

    function automatic logic [1:0] refSel(input int src, input int nearD, input int farD,
                                          input bit wn, input bit wf);
        bit live;
        live = 1'b1;
`ifdef ZERO_REG_GUARD_EN
        live = (src != 0);
`endif
        if (live && wn && src == nearD) return 2'b01;
        if (live && wf && src == farD)  return 2'b10;
        return 2'b00;
    endfunction

    task automatic computeExp();
        expSel[0] = refSel(rs,   destRegMEM, destRegWB,  regWriteMEM, regWriteWB);
        expSel[1] = refSel(rt,   destRegMEM, destRegWB,  regWriteMEM, regWriteWB);
        expSel[2] = refSel(rsID, destRegEX,  destRegMEM, regWriteEX,  regWriteMEM);
        expSel[3] = refSel(rtID, destRegEX,  destRegMEM, regWriteEX,  regWriteMEM);
    endtask

    // Advance model counters by one clock edge using the current expSel.
    task automatic modelTick();
        bit hit [4];
        hit[0] = (expSel[0] == 2'b01) || (expSel[1] == 2'b01);
        hit[1] = (expSel[0] == 2'b10) || (expSel[1] == 2'b10);
        hit[2] = (expSel[2] == 2'b01) || (expSel[3] == 2'b01);
        hit[3] = (expSel[2] == 2'b10) || (expSel[3] == 2'b10);
        for (int k = 0; k < 4; k++) begin
            if (cntClear) begin
                m16[k] = 0;
                m2[k]  = 0;
            end else if (hit[k]) begin
                m16[k] = (m16[k] < 65535) ? m16[k] + 1 : m16[k];
                m2[k]  = (m2[k]  < 3)     ? m2[k]  + 1 : m2[k];
            end
        end
    endtask

    task automatic applyVec(input vec_t v);
        rs = v.vrs; rt = v.vrt; rsID = v.vrsID; rtID = v.vrtID;
        destRegEX = v.dEX; destRegMEM = v.dMEM; destRegWB = v.dWB;
        regWriteEX = v.wEX; regWriteMEM = v.wMEM; regWriteWB = v.wWB;
    endtask

    function automatic vec_t mk(input int a, b, c, d, ex, mem, wb,
                                input bit wex, wmem, wwb,
                                input logic [1:0] e0, e1, e2, e3);
        vec_t v;
        v.vrs = 5'(a); v.vrt = 5'(b); v.vrsID = 5'(c); v.vrtID = 5'(d);
        v.dEX = 5'(ex); v.dMEM = 5'(mem); v.dWB = 5'(wb);
        v.wEX = wex; v.wMEM = wmem; v.wWB = wwb;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    vec_t wbOnly;

    task automatic test_reset();
        Reset = 1'b1; cntClear = 1'b0;
        applyVec(mk(31, 31, 31, 31, 31, 31, 31, 1, 1, 1, 2'b01, 2'b01, 2'b01, 2'b01));
        #2 Reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got16[k] !== 16'd0 || got2[k] !== 2'd0) begin
                errors++;
                $display("FAIL reset_%s got=%0d/%0d want=0", cntName[k], got16[k], got2[k]);
            end
        end
        // Selects must work while the counters are held in reset.
        checks++;
        if (forwardRS !== 2'b01) begin
            errors++;
            $display("FAIL reset_sel forwardRS got=%b want=01", forwardRS);
        end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t tbl [6];
        tbl[0] = mk(31, 31, 31, 31, 31, 31, 31, 1, 1, 1, 2'b01, 2'b01, 2'b01, 2'b01);
        tbl[1] = mk(31, 31, 31, 31, 31, 31, 31, 0, 1, 1, 2'b01, 2'b01, 2'b10, 2'b10);
        tbl[2] = mk(31, 31, 31, 31, 31, 31, 31, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00);
        tbl[3] = mk(31, 31, 27, 23, 23, 11, 13, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01);
        tbl[4] = mk(31, 31, 27, 23, 23, 11, 13, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[5] = wbOnly;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            applyVec(tbl[i]);
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (gotSel[k] !== tbl[i].e[k]) begin
                    errors++;
                    $display("FAIL directed%0d_%s got=%b want=%b", i, selName[k], gotSel[k], tbl[i].e[k]);
                end
            end
        end
    endtask

    task automatic test_counters();
        @(negedge Clock);
        applyVec(wbOnly);
        cntClear = 1'b1;
        @(negedge Clock);
        cntClear = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if (cntFwdWB !== 16'd3) begin
            errors++;
            $display("FAIL count3_cntFwdWB got=%0d want=3", cntFwdWB);
        end
        checks++;
        if (cntFwdMEM !== 16'd0 || cntFwdEX !== 16'd0 || cntFwdIDMEM !== 16'd0) begin
            errors++;
            $display("FAIL count3_others got=%0d,%0d,%0d want=0,0,0", cntFwdMEM, cntFwdEX, cntFwdIDMEM);
        end
        cntClear = 1'b1;
        @(negedge Clock);
        cntClear = 1'b0;
        checks++;
        if (cntFwdWB !== 16'd0) begin
            errors++;
            $display("FAIL clear_cntFwdWB got=%0d want=0", cntFwdWB);
        end
        repeat (2) @(negedge Clock);
        checks++;
        if (cntFwdWB !== 16'd2) begin
            errors++;
            $display("FAIL count2_cntFwdWB got=%0d want=2", cntFwdWB);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (cntFwdWB !== 16'd0 || cntFwdWB2 !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_cntFwdWB got=%0d/%0d want=0", cntFwdWB, cntFwdWB2);
        end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_zero_reg();
        logic [1:0] want;
`ifdef ZERO_REG_GUARD_EN
        want = 2'b00;
`else
        want = 2'b01;
`endif
        @(negedge Clock);
        applyVec(mk(0, 5, 0, 7, 0, 0, 9, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        #1;
        checks++;
        if (forwardRS !== want) begin
            errors++;
            $display("FAIL zero_forwardRS got=%b want=%b", forwardRS, want);
        end
        checks++;
        if (forwardRSID !== want) begin
            errors++;
            $display("FAIL zero_forwardRSID got=%b want=%b", forwardRSID, want);
        end
    endtask

    task automatic test_random();
        @(negedge Clock);
        cntClear = 1'b1;
        @(negedge Clock);
        cntClear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m16[k] = 0;
            m2[k]  = 0;
        end
        for (int i = 0; i <= 500; i++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got16[k] !== 16'(m16[k]) || got2[k] !== 2'(m2[k])) begin
                    errors++;
                    $display("FAIL rand%0d_%s got=%0d/%0d want=%0d/%0d", i, cntName[k],
                             got16[k], got2[k], m16[k], m2[k]);
                end
            end
            if (i == 500) break;
            // Small register range keeps hazards frequent; occasional wide values add misses.
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            rsID = 5'($urandom_range(0, 3)); rtID = 5'($urandom_range(0, 3));
            destRegEX = 5'($urandom_range(0, 3));
            destRegMEM = 5'($urandom_range(0, 3));
            destRegWB = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            regWriteEX = 1'($urandom); regWriteMEM = 1'($urandom); regWriteWB = 1'($urandom);
            cntClear = ($urandom_range(0, 49) == 0);
            #1;
            computeExp();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (gotSel[k] !== expSel[k]) begin
                    errors++;
                    $display("FAIL rand%0d_%s got=%b want=%b", i, selName[k], gotSel[k], expSel[k]);
                end
            end
            modelTick();
            @(negedge Clock);
        end
        cntClear = 1'b0;
    endtask

    task automatic test_saturation();
        @(negedge Clock);
        applyVec(wbOnly);
        cntClear = 1'b1;
        @(negedge Clock);
        cntClear = 1'b0;
        repeat (5) @(negedge Clock);
        checks++;
        if (cntFwdWB2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_cntFwdWB2 got=%0d want=3", cntFwdWB2);
        end
        checks++;
        if (cntFwdWB !== 16'd5) begin
            errors++;
            $display("FAIL sat_cntFwdWB16 got=%0d want=5", cntFwdWB);
        end
        checks++;
        if (cntFwdMEM2 !== 2'd0) begin
            errors++;
            $display("FAIL sat_cntFwdMEM2 got=%0d want=0", cntFwdMEM2);
        end
    endtask

    initial begin
        wbOnly = mk(3, 15, 4, 6, 7, 9, 15, 1, 1, 1, 2'b00, 2'b10, 2'b00, 2'b00);
        test_reset();
        test_directed();
        test_counters();
        test_zero_reg();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
